// File: rtl/probe_grid_writer.sv
`default_nettype none
// ============================================================================
// Module   : probe_grid_writer
// Purpose  : Snapshots NUM_CH probe channels of CH_WIDTH bits on request and
//            streams them, one cell per cycle, into a 1-bit-per-cell
//            character-grid RAM. Clears the whole grid after reset and on
//            demand.
// Ports    : clk         - single clock, rising edge
//            reset       - asynchronous, active-high reset
//            ch_data     - probe values, channel c at [c*CH_WIDTH +: CH_WIDTH]
//            sample      - snapshot-and-redraw request (level, each edge)
//            msb_left    - 0: bit b at column b, 1: at column CH_WIDTH-1-b
//            clear_req   - full-screen clear request
//            busy        - high whenever the FSM is not IDLE
//            done        - one-cycle pulse after the last write of a frame
//            wr_en       - grid RAM write strobe
//            wr_addr     - cell address, row*GRID_COLS + col
//            wr_data     - cell value
//            frame_count - completed frames, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module probe_grid_writer #(
    parameter int GRID_ROWS  = 30,
    parameter int GRID_COLS  = 40,
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = 32,
    parameter int ROW_STRIDE = 1,
    parameter int ADDR_W     = $clog2(GRID_ROWS * GRID_COLS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
    input  logic                         sample,
    input  logic                         msb_left,
    input  logic                         clear_req,
    output logic                         busy,
    output logic                         done,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         wr_data,
    output logic [15:0]                  frame_count
);

    localparam int c_CELLS  = GRID_ROWS * GRID_COLS;
    localparam int c_SNAP_W = NUM_CH * CH_WIDTH;
    localparam int c_CH_W   = (NUM_CH > 1)   ? $clog2(NUM_CH)   : 1;
    localparam int c_BIT_W  = (CH_WIDTH > 1) ? $clog2(CH_WIDTH) : 1;

    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(c_CELLS - 1);
    localparam logic [ADDR_W-1:0]  c_ROW_STEP  = ADDR_W'(ROW_STRIDE * GRID_COLS);
    localparam logic [ADDR_W-1:0]  c_COL_MAX   = ADDR_W'(CH_WIDTH - 1);
    localparam logic [c_CH_W-1:0]  c_LAST_CH   = c_CH_W'(NUM_CH - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(CH_WIDTH - 1);

    localparam logic [1:0] c_ST_CLEAR = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;

    logic [1:0]          r_state;
    logic                r_fin;          // every write of the sequence issued
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [c_CH_W-1:0]   r_ch;
    logic [c_BIT_W-1:0]  r_bit;
    logic [ADDR_W-1:0]   r_row_base;
    logic [c_SNAP_W-1:0] r_snap;
    logic                r_msb_left;
    logic                r_pend_sample;
    logic                r_pend_clear;

    logic                r_busy;
    logic                r_done;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_wr_data;
    logic [15:0]         r_frame_count;

    logic                w_want_clear;
    logic                w_want_sample;
    logic                w_dispatch;
    logic [CH_WIDTH-1:0] w_word;
    logic [ADDR_W-1:0]   w_col;

    assign w_want_clear  = clear_req | r_pend_clear;
    assign w_want_sample = sample | r_pend_sample;

    // Dispatch happens in IDLE and on the extra cycle that follows the last
    // write of a CLEAR or WRITE sequence, so a pending request is accepted
    // on the same edge that finishes the previous sequence.
    assign w_dispatch = r_fin ||
                        !((r_state == c_ST_CLEAR) || (r_state == c_ST_WRITE));

    // The snapshot shifts down one channel at a time, so the current channel
    // always sits in the low word.
    assign w_word = r_snap[CH_WIDTH-1:0];
    assign w_col  = r_msb_left ? (c_COL_MAX - ADDR_W'(r_bit)) : ADDR_W'(r_bit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_CLEAR;
            r_fin         <= 1'b0;
            r_clr_addr    <= '0;
            r_ch          <= '0;
            r_bit         <= '0;
            r_row_base    <= '0;
            r_snap        <= '0;
            r_msb_left    <= 1'b0;
            r_pend_sample <= 1'b0;
            r_pend_clear  <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= 1'b0;

            if (w_dispatch) begin
                if (r_state == c_ST_WRITE) begin
                    r_done        <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                end
                r_fin <= 1'b0;

                if (w_want_clear) begin
                    r_state       <= c_ST_CLEAR;
                    r_clr_addr    <= '0;
                    r_pend_clear  <= 1'b0;
                    r_pend_sample <= w_want_sample;
                    r_busy        <= 1'b1;
                end else if (w_want_sample) begin
                    // Pending samples capture the data present now, at
                    // acceptance, not at the time of the original request.
                    r_state       <= c_ST_WRITE;
                    r_snap        <= ch_data;
                    r_msb_left    <= msb_left;
                    r_pend_sample <= 1'b0;
                    r_ch          <= '0;
                    r_bit         <= '0;
                    r_row_base    <= '0;
                    r_busy        <= 1'b1;
                end else begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                // Requests arriving mid-sequence are remembered, never abort.
                if (sample) begin
                    r_pend_sample <= 1'b1;
                end
                if (clear_req) begin
                    r_pend_clear <= 1'b1;
                end

                r_wr_en <= 1'b1;

                if (r_state == c_ST_CLEAR) begin
                    r_wr_addr <= r_clr_addr;
                    r_wr_data <= 1'b0;
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_fin <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end else begin
                    r_wr_addr <= r_row_base + w_col;
                    r_wr_data <= w_word[r_bit];
                    if (r_bit == c_LAST_BIT) begin
                        r_bit      <= '0;
                        r_snap     <= r_snap >> CH_WIDTH;
                        r_row_base <= r_row_base + c_ROW_STEP;
                        if (r_ch == c_LAST_CH) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_ch <= r_ch + c_CH_W'(1);
                        end
                    end else begin
                        r_bit <= r_bit + c_BIT_W'(1);
                    end
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
